// File: rtl/track_stepper_pkg.sv
// Shared widths, track word layout and phase-to-coil tables for the track stepper.
// HALF_STEP_EN selects 8-phase half-step drive; otherwise 4-phase wave drive.
package track_stepper_pkg;

  localparam int NUM_TRACKS  = 4;
  localparam int PERIOD_W    = 16;
  localparam int TRAVEL_W    = 8;
  localparam int PACKET_SIZE = NUM_TRACKS * (PERIOD_W + TRAVEL_W) / 8;

  typedef struct packed {
    logic [PERIOD_W-1:0] period;
    logic [TRAVEL_W-1:0] travel;
  } track_word_t;

  typedef enum logic {DIR_FWD = 1'b0, DIR_REV = 1'b1} dir_t;

  localparam logic [3:0] WAVE_TAB [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
  localparam logic [3:0] HALF_TAB [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                          4'b0010, 4'b0011, 4'b0001, 4'b1001};

`ifdef HALF_STEP_EN
  localparam int PHASE_W = 3;
`else
  localparam int PHASE_W = 2;
`endif

  // NPH is a power of two, so phase arithmetic wraps for free.
  typedef logic [PHASE_W-1:0] phase_t;

  function automatic logic [3:0] coil_decode(input phase_t phase);
`ifdef HALF_STEP_EN
    return HALF_TAB[phase];
`else
    return WAVE_TAB[phase];
`endif
  endfunction

  function automatic logic [TRAVEL_W-1:0] travel_eff(input logic [TRAVEL_W-1:0] travel);
    return (travel == '0) ? TRAVEL_W'(1) : travel;
  endfunction

endpackage

// File: rtl/track_stepper_if.sv
// Load/word input and coil/step/active outputs of one track stepper.
interface track_stepper_if;
  import track_stepper_pkg::*;

  logic        i_load;
  track_word_t i_word;
  logic        o_a;
  logic        o_b;
  logic        o_c;
  logic        o_d;
  logic        o_step;
  logic        o_active;

  modport master (output i_load, i_word, input o_a, o_b, o_c, o_d, o_step, o_active);
  modport slave  (input i_load, i_word, output o_a, o_b, o_c, o_d, o_step, o_active);

endinterface

// File: rtl/track_stepper_tick_prescaler.sv
// Step-timer prescaler: one tick every PRESCALE clocks, held at zero while cleared.
module tick_prescaler #(
  parameter int PRESCALE = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] r_count;
  logic          w_wrap;

  assign w_wrap = (r_count == CW'(PRESCALE - 1));
  assign o_tick = w_wrap & ~i_clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear || w_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/track_stepper.sv
// Per-track coil sequencer: steps the head back and forth over the travel range.
// HALF_STEP_EN selects 8-phase half-step coil drive (see package).
module track_stepper
  import track_stepper_pkg::*;
#(
  parameter int PRESCALE = 50
) (
  input logic            clk,
  input logic            rst,
  track_stepper_if.slave bus
);

  logic                w_tick;
  logic                w_active;
  logic                w_step_fire;
  logic                w_apply;
  track_word_t         w_word;

  logic [PERIOD_W-1:0] r_period, w_period_nx;
  logic [PERIOD_W-1:0] r_pcount, w_pcount_nx;
  logic [TRAVEL_W-1:0] r_travel, w_travel_nx;
  logic [TRAVEL_W-1:0] r_pos,    w_pos_nx;
  track_word_t         r_pend,   w_pend_nx;
  logic                r_pend_vld, w_pend_vld_nx;
  phase_t              r_phase,  w_phase_nx;
  dir_t                r_dir,    w_dir_nx;
  logic [3:0]          r_coils,  w_coils_nx;
  logic                r_step;

  assign w_active    = (r_period != '0);
  assign w_step_fire = w_active & w_tick & (r_pcount == r_period - 1'b1);

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .i_clear (~w_active),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_period_nx   = r_period;
    w_pcount_nx   = r_pcount;
    w_travel_nx   = r_travel;
    w_pos_nx      = r_pos;
    w_pend_nx     = r_pend;
    w_pend_vld_nx = r_pend_vld;
    w_phase_nx    = r_phase;
    w_dir_nx      = r_dir;
    w_apply       = 1'b0;
    w_word        = bus.i_word;

    if (w_active && w_tick) begin
      w_pcount_nx = w_step_fire ? '0 : r_pcount + 1'b1;
    end

    // The step always advances with the values in force before this edge.
    if (w_step_fire) begin
      if (r_dir == DIR_FWD) begin
        w_phase_nx = r_phase + 1'b1;
        w_pos_nx   = r_pos + 1'b1;
        if (w_pos_nx == travel_eff(r_travel)) w_dir_nx = DIR_REV;
      end else begin
        w_phase_nx = r_phase - 1'b1;
        w_pos_nx   = r_pos - 1'b1;
        if (w_pos_nx == '0) w_dir_nx = DIR_FWD;
      end
    end

    // Running tracks defer new words to the next step edge; mutes take effect at once.
    if (bus.i_load) begin
      if (!w_active || (bus.i_word.period == '0) || w_step_fire) begin
        w_apply       = 1'b1;
        w_pend_vld_nx = 1'b0;
      end else begin
        w_pend_nx     = bus.i_word;
        w_pend_vld_nx = 1'b1;
      end
    end else if (w_step_fire && r_pend_vld) begin
      w_apply       = 1'b1;
      w_word        = r_pend;
      w_pend_vld_nx = 1'b0;
    end

    if (w_apply) begin
      w_period_nx = w_word.period;
      w_pcount_nx = '0;
      // A mute word leaves travel and direction untouched so unmute resumes cleanly.
      if (w_word.period != '0) begin
        w_travel_nx = w_word.travel;
        if (w_pos_nx >= travel_eff(w_word.travel)) w_dir_nx = DIR_REV;
      end
    end

    w_coils_nx = (w_period_nx != '0) ? coil_decode(w_phase_nx) : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period   <= '0;
      r_pcount   <= '0;
      r_travel   <= '0;
      r_pos      <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_phase    <= '0;
      r_dir      <= DIR_FWD;
      r_coils    <= 4'b0000;
      r_step     <= 1'b0;
    end else begin
      r_period   <= w_period_nx;
      r_pcount   <= w_pcount_nx;
      r_travel   <= w_travel_nx;
      r_pos      <= w_pos_nx;
      r_pend     <= w_pend_nx;
      r_pend_vld <= w_pend_vld_nx;
      r_phase    <= w_phase_nx;
      r_dir      <= w_dir_nx;
      r_coils    <= w_coils_nx;
      r_step     <= w_step_fire;
    end
  end

  assign bus.o_a      = r_coils[3];
  assign bus.o_b      = r_coils[2];
  assign bus.o_c      = r_coils[1];
  assign bus.o_d      = r_coils[0];
  assign bus.o_step   = r_step;
  assign bus.o_active = w_active;

endmodule
